// File: rtl/gpio_pulpino_comm.sv
// Byte-serial bridge between a host 32-bit word interface and the PULPino 8-bit GPIO bus.
// In: 4 bytes, one per acknowledged turn code. Out: 4 captured bytes form one atomic 32-bit word.
module gpio_pulpino_comm (
    input  logic        clk,
    input  logic        reset_i,
    input  logic [31:0] read_data,
    input  logic        do_read,
    output logic [7:0]  gpio_data_in,
    output logic [1:0]  data_in_io_turn,
    input  logic [1:0]  data_in_pulpino_turn,
    output logic        data_in_done,
    input  logic [7:0]  gpio_data_out,
    input  logic [1:0]  data_out_pulpino_turn,
    output logic        data_out_io_turn,
    output logic [31:0] write_data,
    output logic        data_out_done
);

    typedef enum logic [2:0] {
        IN_IDLE  = 3'd0,
        IN_BYTE0 = 3'd1,
        IN_BYTE1 = 3'd2,
        IN_BYTE2 = 3'd3,
        IN_BYTE3 = 3'd4
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_W0 = 2'd0,
        OUT_W1 = 2'd1,
        OUT_W2 = 2'd2,
        OUT_W3 = 2'd3
    } out_state_t;

    // Turn code for byte k; shared by both channels.
    function automatic logic [1:0] turn_code(input logic [1:0] k);
        logic [1:0] code;
        case (k)
            2'd0:    code = 2'b01;
            2'd1:    code = 2'b00;
            2'd2:    code = 2'b01;
            default: code = 2'b10;
        endcase
        return code;
    endfunction

    in_state_t   r_in_state;
    in_state_t   w_in_state_nxt;
    logic [31:0] r_in_word;
    logic [31:0] w_in_word_nxt;
    logic [1:0]  w_in_idx;
    logic        w_in_ack;
    logic        w_in_load;
    logic        w_in_done_nxt;
    logic [7:0]  w_gpio_in_nxt;
    logic [1:0]  w_in_io_turn_nxt;
    logic [7:0]  r_gpio_data_in;
    logic [1:0]  r_in_io_turn;
    logic        r_in_done;

    out_state_t  r_out_state;
    out_state_t  w_out_state_nxt;
    logic [1:0]  w_out_idx;
    logic [1:0]  w_out_turn;
    logic        w_out_match;
    logic [23:0] r_out_stage;
    logic [31:0] r_write_data;
    logic        r_out_io_turn;
    logic        r_out_done;

    always_comb begin
        w_in_idx = 2'd0;
        case (r_in_state)
            IN_BYTE1: w_in_idx = 2'd1;
            IN_BYTE2: w_in_idx = 2'd2;
            IN_BYTE3: w_in_idx = 2'd3;
            default:  w_in_idx = 2'd0;
        endcase
    end

    assign w_in_ack = (data_in_pulpino_turn == turn_code(w_in_idx));

    always_comb begin
        w_in_state_nxt = r_in_state;
        w_in_load      = 1'b0;
        w_in_done_nxt  = 1'b0;
        case (r_in_state)
            IN_IDLE: begin
                if (do_read) begin
                    w_in_state_nxt = IN_BYTE0;
                    w_in_load      = 1'b1;
                end
            end
            IN_BYTE0: if (w_in_ack) w_in_state_nxt = IN_BYTE1;
            IN_BYTE1: if (w_in_ack) w_in_state_nxt = IN_BYTE2;
            IN_BYTE2: if (w_in_ack) w_in_state_nxt = IN_BYTE3;
            IN_BYTE3: begin
                if (w_in_ack) begin
                    w_in_state_nxt = IN_IDLE;
                    w_in_done_nxt  = 1'b1;
                end
            end
            default: w_in_state_nxt = IN_IDLE;
        endcase
    end

    assign w_in_word_nxt = w_in_load ? read_data : r_in_word;

    // Outputs are decoded from the next state so they are valid right after the edge.
    always_comb begin
        w_gpio_in_nxt    = 8'h00;
        w_in_io_turn_nxt = 2'b00;
        case (w_in_state_nxt)
            IN_BYTE0: begin
                w_gpio_in_nxt    = w_in_word_nxt[7:0];
                w_in_io_turn_nxt = 2'b10;
            end
            IN_BYTE1: begin
                w_gpio_in_nxt    = w_in_word_nxt[15:8];
                w_in_io_turn_nxt = 2'b11;
            end
            IN_BYTE2: begin
                w_gpio_in_nxt    = w_in_word_nxt[23:16];
                w_in_io_turn_nxt = 2'b10;
            end
            IN_BYTE3: begin
                w_gpio_in_nxt    = w_in_word_nxt[31:24];
                w_in_io_turn_nxt = 2'b11;
            end
            default: begin
                w_gpio_in_nxt    = 8'h00;
                w_in_io_turn_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            r_in_state     <= IN_IDLE;
            r_in_word      <= 32'h0;
            r_gpio_data_in <= 8'h00;
            r_in_io_turn   <= 2'b00;
            r_in_done      <= 1'b0;
        end else begin
            r_in_state     <= w_in_state_nxt;
            r_in_word      <= w_in_word_nxt;
            r_gpio_data_in <= w_gpio_in_nxt;
            r_in_io_turn   <= w_in_io_turn_nxt;
            r_in_done      <= w_in_done_nxt;
        end
    end

    assign w_out_idx   = r_out_state;
    assign w_out_turn  = turn_code(w_out_idx);
    assign w_out_match = (data_out_pulpino_turn == w_out_turn);

    always_comb begin
        w_out_state_nxt = r_out_state;
        if (w_out_match) begin
            case (r_out_state)
                OUT_W0:  w_out_state_nxt = OUT_W1;
                OUT_W1:  w_out_state_nxt = OUT_W2;
                OUT_W2:  w_out_state_nxt = OUT_W3;
                default: w_out_state_nxt = OUT_W0;
            endcase
        end
    end

    // The last byte bypasses staging so write_data updates in one edge.
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            r_out_state   <= OUT_W0;
            r_out_stage   <= 24'h0;
            r_write_data  <= 32'h0;
            r_out_io_turn <= 1'b0;
            r_out_done    <= 1'b0;
        end else begin
            r_out_state <= w_out_state_nxt;
            r_out_done  <= 1'b0;
            if (w_out_match) begin
                r_out_io_turn <= w_out_turn[0];
                case (r_out_state)
                    OUT_W0: r_out_stage[7:0]   <= gpio_data_out;
                    OUT_W1: r_out_stage[15:8]  <= gpio_data_out;
                    OUT_W2: r_out_stage[23:16] <= gpio_data_out;
                    default: begin
                        r_write_data <= {gpio_data_out, r_out_stage};
                        r_out_done   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign gpio_data_in     = r_gpio_data_in;
    assign data_in_io_turn  = r_in_io_turn;
    assign data_in_done     = r_in_done;
    assign data_out_io_turn = r_out_io_turn;
    assign write_data       = r_write_data;
    assign data_out_done    = r_out_done;

endmodule

// File: tb/tb_gpio_pulpino_comm.sv
// Scoreboard bench for gpio_pulpino_comm: stimulus queues expected output changes,
// per-channel monitors compare every observed change against the queue head.
module tb_gpio_pulpino_comm;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] read_data = 32'h0;
    logic        do_read = 1'b0;
    logic [7:0]  gpio_data_in;
    logic [1:0]  data_in_io_turn;
    logic [1:0]  data_in_pulpino_turn = 2'b00;
    logic        data_in_done;
    logic [7:0]  gpio_data_out = 8'h00;
    logic [1:0]  data_out_pulpino_turn = 2'b00;
    logic        data_out_io_turn;
    logic [31:0] write_data;
    logic        data_out_done;

    always #5 clk = ~clk;

    gpio_pulpino_comm dut (
        .clk                   (clk),
        .reset_i               (reset_i),
        .read_data             (read_data),
        .do_read               (do_read),
        .gpio_data_in          (gpio_data_in),
        .data_in_io_turn       (data_in_io_turn),
        .data_in_pulpino_turn  (data_in_pulpino_turn),
        .data_in_done          (data_in_done),
        .gpio_data_out         (gpio_data_out),
        .data_out_pulpino_turn (data_out_pulpino_turn),
        .data_out_io_turn      (data_out_io_turn),
        .write_data            (write_data),
        .data_out_done         (data_out_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [10:0] q_in[$];
    logic [33:0] q_out[$];
    logic [31:0] m_wd = 32'h0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [1:0] tb_turn(input int k);
        logic [1:0] t;
        case (k)
            0:       t = 2'b01;
            1:       t = 2'b00;
            2:       t = 2'b01;
            default: t = 2'b10;
        endcase
        return t;
    endfunction

    function automatic void exp_in(input logic [7:0] b, input logic [1:0] io, input logic d);
        q_in.push_back({d, io, b});
    endfunction

    function automatic void exp_out(input logic d, input logic io, input logic [31:0] wd);
        q_out.push_back({d, io, wd});
    endfunction

    // In-channel monitor: {done, io_turn, gpio_data_in}
    logic [10:0] in_prev = 11'h0;
    logic [10:0] in_cur;
    always @(negedge clk) begin
        if (mon_en) begin
            in_cur = {data_in_done, data_in_io_turn, gpio_data_in};
            if (in_cur !== in_prev) begin
                if (q_in.size() == 0) begin
                    n_checks++;
                    $display("FAIL in_unexpected_event: got %0h, expected no change from %0h", in_cur, in_prev);
                end else begin
                    chk("in_event", 64'(in_cur), 64'(q_in.pop_front()));
                end
            end
            in_prev = in_cur;
        end
    end

    // Out-channel monitor: {done, io_turn, write_data}
    logic [33:0] out_prev = 34'h0;
    logic [33:0] out_cur;
    always @(negedge clk) begin
        if (mon_en) begin
            out_cur = {data_out_done, data_out_io_turn, write_data};
            if (out_cur !== out_prev) begin
                if (q_out.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected_event: got %0h, expected no change from %0h", out_cur, out_prev);
                end else begin
                    chk("out_event", 64'(out_cur), 64'(q_out.pop_front()));
                end
            end
            out_prev = out_cur;
        end
    end

    task automatic in_word(input logic [31:0] w);
        exp_in(w[7:0], 2'b10, 1'b0);
        read_data = w;
        do_read   = 1'b1;
        tick();
        do_read = 1'b0;
        exp_in(w[15:8], 2'b11, 1'b0);
        data_in_pulpino_turn = 2'b01;
        tick();
        exp_in(w[23:16], 2'b10, 1'b0);
        data_in_pulpino_turn = 2'b00;
        tick();
        exp_in(w[31:24], 2'b11, 1'b0);
        data_in_pulpino_turn = 2'b01;
        tick();
        exp_in(8'h00, 2'b00, 1'b1);
        exp_in(8'h00, 2'b00, 1'b0);
        data_in_pulpino_turn = 2'b10;
        tick();
        tick();
    endtask

    task automatic out_word(input logic [31:0] w);
        logic [1:0] t;
        for (int k = 0; k < 4; k++) begin
            t = tb_turn(k);
            if (k < 3) begin
                exp_out(1'b0, t[0], m_wd);
            end else begin
                exp_out(1'b1, t[0], w);
                m_wd = w;
                exp_out(1'b0, t[0], w);
            end
            gpio_data_out         = w[8*k +: 8];
            data_out_pulpino_turn = t;
            tick();
            tick();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gpio_data_in"}, 64'(gpio_data_in), 64'h0);
        chk({tag, "_in_io_turn"}, 64'(data_in_io_turn), 64'h0);
        chk({tag, "_in_done"}, 64'(data_in_done), 64'h0);
        chk({tag, "_out_io_turn"}, 64'(data_out_io_turn), 64'h0);
        chk({tag, "_write_data"}, 64'(write_data), 64'h0);
        chk({tag, "_out_done"}, 64'(data_out_done), 64'h0);
    endtask

    initial begin
        // Reset and idle
        reset_i = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_i = 1'b1;
        mon_en  = 1'b1;
        repeat (3) tick();

        // Nominal transfers
        in_word(32'h1234ABCD);
        data_out_pulpino_turn = 2'b11;
        out_word(32'h1234ABCD);
        data_out_pulpino_turn = 2'b11;
        tick();

        // Wrong and held turns, ignored do_read
        exp_in(8'hD8, 2'b10, 1'b0);
        read_data = 32'hA5B6C7D8;
        do_read   = 1'b1;
        tick();
        do_read = 1'b0;
        data_in_pulpino_turn = 2'b10;
        tick();
        data_in_pulpino_turn = 2'b00;
        tick();
        exp_in(8'hC7, 2'b11, 1'b0);
        data_in_pulpino_turn = 2'b01;
        repeat (5) tick();
        read_data = 32'hFFFFFFFF;
        do_read   = 1'b1;
        tick();
        do_read = 1'b0;
        exp_in(8'hB6, 2'b10, 1'b0);
        data_in_pulpino_turn = 2'b00;
        tick();
        exp_in(8'hA5, 2'b11, 1'b0);
        data_in_pulpino_turn = 2'b01;
        tick();
        exp_in(8'h00, 2'b00, 1'b1);
        exp_in(8'h00, 2'b00, 1'b0);
        data_in_pulpino_turn = 2'b10;
        tick();
        tick();

        // Reset after two bytes in both channels
        exp_in(8'h11, 2'b10, 1'b0);
        read_data = 32'h44332211;
        do_read   = 1'b1;
        tick();
        do_read = 1'b0;
        exp_in(8'h22, 2'b11, 1'b0);
        data_in_pulpino_turn = 2'b01;
        tick();
        exp_in(8'h33, 2'b10, 1'b0);
        data_in_pulpino_turn = 2'b00;
        tick();
        exp_out(1'b0, 1'b1, m_wd);
        gpio_data_out         = 8'h99;
        data_out_pulpino_turn = 2'b01;
        tick();
        exp_out(1'b0, 1'b0, m_wd);
        gpio_data_out         = 8'h88;
        data_out_pulpino_turn = 2'b00;
        tick();
        data_out_pulpino_turn = 2'b11;
        exp_in(8'h00, 2'b00, 1'b0);
        if (m_wd != 32'h0) exp_out(1'b0, 1'b0, 32'h0);
        m_wd    = 32'h0;
        reset_i = 1'b0;
        tick();
        tick();
        chk_all_zero("midreset");
        reset_i = 1'b1;
        repeat (2) tick();
        in_word(32'h0BADF00D);
        out_word(32'hCAFE1234);
        data_out_pulpino_turn = 2'b11;
        tick();

        // Concurrent, interleaved transfers
        fork
            begin
                in_word(32'hDEADBEEF);
            end
            begin
                tick();
                out_word(32'h01020304);
            end
        join
        repeat (4) tick();

        chk("in_queue_drained", 64'(q_in.size()), 64'h0);
        chk("out_queue_drained", 64'(q_out.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
